// File: rtl/sub_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// DIGIT_W : width of one serial slice in bits.
// state_e : control FSM states (IDLE accept, RUN compute slices, DONE present).
package sub_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_slice.sv
// Combinational 4-bit subtract slice: {bo, d} = x - y - bi.
// Ports:
//   x  : minuend digit
//   y  : subtrahend digit
//   bi : borrow in
//   d  : difference digit
//   bo : borrow out
module sub_slice
  import sub_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo
);

  logic [DIGIT_W:0] sum;

  // Two's-complement form: x + ~y + ~bi; a borrow is the absence of carry.
  always_comb begin
    sum = {1'b0, x} + {1'b0, ~y} + {{DIGIT_W{1'b0}}, ~bi};
    d   = sum[DIGIT_W-1:0];
    bo  = ~sum[DIGIT_W];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Nibble-serial subtractor: diff = (a - b - bin) mod 2^WIDTH, one 4-bit
// slice per clock, LSB slice first, borrow held in a flop between slices.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, bin sampled on accept)
//   out_valid / out_ready: result handshake (diff, bout, ovf held in DONE)
//   diff                 : difference, valid while out_valid
//   bout                 : unsigned borrow out (a < b + bin)
//   ovf                  : signed overflow of a - b - bin
//   busy                 : operation in RUN or DONE
// WIDTH must be a multiple of 4 and at least 8.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT_W-1:0] d4;
  logic               bo;

  sub_slice u_slice (
    .x  (a_sr_q[DIGIT_W-1:0]),
    .y  (b_sr_q[DIGIT_W-1:0]),
    .bi (borrow_q),
    .d  (d4),
    .bo (bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d   = a;
          b_sr_d   = b;
          borrow_d = bin;
          a_msb_d  = a[WIDTH-1];
          b_msb_d  = b[WIDTH-1];
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Result digits enter at the top so the first (LSB) digit ends up
        // at bit 0 after NSLICE shifts.
        diff_d   = {d4, diff_q[WIDTH-1:DIGIT_W]};
        a_sr_d   = a_sr_q >> DIGIT_W;
        b_sr_d   = b_sr_q >> DIGIT_W;
        borrow_d = bo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          bout_d  = bo;
          // Overflow only possible when operand signs differ and the
          // result sign disagrees with the minuend.
          ovf_d   = (a_msb_q != b_msb_q) && (d4[DIGIT_W-1] != a_msb_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 16;
  localparam int unsigned NS = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_acc  = 0;
  int n_hs   = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready) n_acc <= n_acc + 1;
    if (rst_n && out_valid && out_ready) n_hs <= n_hs + 1;
  end

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic rbin, output logic [W-1:0] rd,
                                  output logic rbo, output logic rov);
    int ua, ub, sa, sb, res;
    ua  = int'(ra);
    ub  = int'(rb);
    sa  = int'($signed(ra));
    sb  = int'($signed(rb));
    rd  = W'(ua - ub - int'(rbin));
    rbo = (ua < ub + int'(rbin));
    res = sa - sb - int'(rbin);
    rov = (res > 32767) || (res < -32768);
  endfunction

  // Presents one operation, stalls out_ready for 'stall' cycles once the
  // result is valid, then completes the handshake.
  task automatic drive_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input int stall,
                          output logic [W-1:0] rd, output logic rbo, output logic rov,
                          output int lat, output int acc_at, output bit to);
    int n;
    to = 1'b0;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    acc_at = cyc;
    #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!out_valid) to = 1'b1;
    for (int i = 0; i < stall; i++) begin @(posedge clk); #1; end
    rd = diff; rbo = bout; rov = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic [W-1:0] gd, input logic gbo,
                          input logic gov, input bit to);
    logic [W-1:0] ed; logic ebo, eov;
    ref_sub(ta, tb_, tbin, ed, ebo, eov);
    n_cmp++;
    if (to || gd !== ed || gbo !== ebo || gov !== eov) begin
      n_fail++;
      $display("FAIL %s: a=%h b=%h bin=%0d got diff=%h bout=%b ovf=%b timeout=%0d want diff=%h bout=%b ovf=%b",
               nm, ta, tb_, tbin, gd, gbo, gov, to, ed, ebo, eov);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({out_valid, busy, bout, ovf, diff} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b busy=%b bout=%b ovf=%b diff=%h ir=%b want all 0, ir=1",
               out_valid, busy, bout, ovf, diff, in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] d; logic bo, ov; int lat, acc; bit to;
    drive_op(16'h1234, 16'h0234, 1'b0, 0, d, bo, ov, lat, acc, to);
    n_cmp++;
    if (lat != NS) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d", lat, NS);
    end
    n_cmp++;
    if (d !== 16'h1000 || bo !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_1234: got %h/%b/%b want 1000/0/0", d, bo, ov);
    end
  endtask

  task automatic test_borrow_ovf();
    logic [W-1:0] d; logic bo, ov; int lat, acc; bit to;
    drive_op(16'h0000, 16'h0001, 1'b0, 0, d, bo, ov, lat, acc, to);
    check_op("borrow_0m1", 16'h0000, 16'h0001, 1'b0, d, bo, ov, to);
    drive_op(16'h0005, 16'h0005, 1'b1, 0, d, bo, ov, lat, acc, to);
    check_op("borrow_bin", 16'h0005, 16'h0005, 1'b1, d, bo, ov, to);
    drive_op(16'h8000, 16'h0001, 1'b0, 1, d, bo, ov, lat, acc, to);
    n_cmp++;
    if (d !== 16'h7FFF || ov !== 1'b1 || bo !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_neg: got %h/%b/%b want 7fff/0/1", d, bo, ov);
    end
    drive_op(16'h7FFF, 16'hFFFF, 1'b0, 2, d, bo, ov, lat, acc, to);
    n_cmp++;
    if (d !== 16'h8000 || ov !== 1'b1 || bo !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pos: got %h/%b/%b want 8000/1/1", d, bo, ov);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] d0, d; logic b0, o0, bo, ov; int lat, acc, n; bit to, bad;
    @(negedge clk);
    a = 16'hBEEF; b = 16'h1234; bin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    d0 = diff; b0 = bout; o0 = ovf;
    check_op("bp_result", 16'hBEEF, 16'h1234, 1'b1, d0, b0, o0, !out_valid);
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== d0 || bout !== b0 || ovf !== o0)
        bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: outputs changed during stall (ov=%b ir=%b diff=%h want 1/0/%h)",
               out_valid, in_ready, diff, d0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got ir=%b ov=%b want 1/0", in_ready, out_valid);
    end
    drive_op(16'h0F0F, 16'hF0F0, 1'b0, 0, d, bo, ov, lat, acc, to);
    check_op("bp_next", 16'h0F0F, 16'hF0F0, 1'b0, d, bo, ov, to);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] d; logic bo, ov; int lat, acc1, acc2; bit to;
    drive_op(16'h4321, 16'h1111, 1'b0, 0, d, bo, ov, lat, acc1, to);
    check_op("b2b_1", 16'h4321, 16'h1111, 1'b0, d, bo, ov, to);
    drive_op(16'h0001, 16'h8000, 1'b1, 0, d, bo, ov, lat, acc2, to);
    check_op("b2b_2", 16'h0001, 16'h8000, 1'b1, d, bo, ov, to);
    n_cmp++;
    if (acc2 - acc1 != NS + 2) begin
      n_fail++;
      $display("FAIL b2b_interval: got %0d want %0d", acc2 - acc1, NS + 2);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] d; logic bo, ov; int lat, acc; bit to, bad;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, busy, bout, ovf, diff} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got ov=%b busy=%b bout=%b ovf=%b diff=%h ir=%b want all 0, ir=1",
               out_valid, busy, bout, ovf, diff, in_ready);
    end
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin
      n_fail++;
      $display("FAIL reset_stale: got out_valid=1 want 0 after reset");
    end
    drive_op(16'h0010, 16'h0001, 1'b0, 0, d, bo, ov, lat, acc, to);
    n_cmp++;
    if (to || d !== 16'h000F || bo !== 1'b0 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: got %h/%b/%b want 000f/0/0", d, bo, ov);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, d; logic rbi, bo, ov; int lat, acc, acc0, hs0; bit to;
    acc0 = n_acc; hs0 = n_hs;
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom); rb = W'($urandom); rbi = 1'($urandom);
      if (i % 8 == 0) ra = rb;
      drive_op(ra, rb, rbi, int'($urandom_range(0, 3)), d, bo, ov, lat, acc, to);
      check_op("random", ra, rb, rbi, d, bo, ov, to);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (n_acc - acc0 != 1000 || n_hs - hs0 != 1000) begin
      n_fail++;
      $display("FAIL random_handshakes: got acc=%0d hs=%0d want 1000/1000", n_acc - acc0, n_hs - hs0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
